// File: rtl/axi_llc_pkg.sv
// Shared LLC definitions: cache-unit indices and default way payload types.
package axi_llc_pkg;

    // Requesting cache units, in arbitration index order.
    localparam int unsigned WChanUnit = 0;
    localparam int unsigned RChanUnit = 1;
    localparam int unsigned EvictUnit = 2;
    localparam int unsigned RefilUnit = 3;
    localparam int unsigned NumUnits  = 4;

    // Default request payload towards the data ways; `we` selects write vs read.
    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } way_inp_def_t;

    // Default read-response payload coming back from the data ways.
    typedef struct packed {
        logic [31:0] data;
    } way_oup_def_t;

endpackage

// File: rtl/stream_fifo.sv
// Small valid/ready style FIFO with occupancy output and optional fall-through.
module stream_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 2,
    parameter type         T            = logic,
    localparam int unsigned AddrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic           testmode_i,
    output logic           full_o,
    output logic           empty_o,
    output logic [AddrW:0] usage_o,
    input  T               data_i,
    input  logic           push_i,
    output T               data_o,
    input  logic           pop_i
);

    T                 mem_q [DEPTH];
    logic [AddrW-1:0] wrPtr_q, wrPtr_d;
    logic [AddrW-1:0] rdPtr_q, rdPtr_d;
    logic [AddrW:0]   count_q, count_d;
    logic             storeEmpty;
    logic             doPush;
    logic             doPop;
    logic             unusedTestmode;

    assign unusedTestmode = testmode_i;
    assign usage_o        = count_q;

    // Status flags, effective push/pop and pointer/occupancy updates.
    always_comb begin
        storeEmpty = (count_q == '0);
        full_o     = (count_q == (AddrW + 1)'(DEPTH));
        empty_o    = storeEmpty & ~(FALL_THROUGH & push_i);
        data_o     = (FALL_THROUGH && storeEmpty) ? data_i : mem_q[rdPtr_q];
        doPush     = push_i & ~full_o;
        doPop      = pop_i & ~empty_o;
        if (FALL_THROUGH && storeEmpty && doPush && doPop) begin
            doPush = 1'b0;
            doPop  = 1'b0;
        end
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = (wrPtr_q == AddrW'(DEPTH - 1)) ? '0 : wrPtr_q + AddrW'(1);
        end
        if (doPop) begin
            rdPtr_d = (rdPtr_q == AddrW'(DEPTH - 1)) ? '0 : rdPtr_q + AddrW'(1);
        end
        if (doPush && !doPop) begin
            count_d = count_q + (AddrW + 1)'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - (AddrW + 1)'(1);
        end
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= T'(0);
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/axi_llc_way_arbiter.sv
// Way arbiter: round-robin grant of cache units onto the data ways, with read
// responses steered back to the unit that issued the corresponding read.
module axi_llc_way_arbiter
    import axi_llc_pkg::*;
#(
    parameter int unsigned NumUnits  = axi_llc_pkg::NumUnits,
    parameter int unsigned MaxReads  = 2,
    parameter type         way_inp_t = axi_llc_pkg::way_inp_def_t,
    parameter type         way_oup_t = axi_llc_pkg::way_oup_def_t
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_i,
    input  way_inp_t [NumUnits-1:0] req_i,
    input  logic [NumUnits-1:0]     req_valid_i,
    output logic [NumUnits-1:0]     req_ready_o,
    output way_inp_t                way_inp_o,
    output logic                    way_inp_valid_o,
    input  logic                    way_inp_ready_i,
    input  way_oup_t                way_oup_i,
    input  logic                    way_oup_valid_i,
    output logic                    way_oup_ready_o,
    output way_oup_t                rsp_o,
    output logic [NumUnits-1:0]     rsp_valid_o,
    input  logic [NumUnits-1:0]     rsp_ready_i
);

    localparam int unsigned IdxW  = (NumUnits > 1) ? $clog2(NumUnits) : 1;
    localparam int unsigned UsedW = ((MaxReads > 1) ? $clog2(MaxReads) : 1) + 1;
    typedef logic [IdxW-1:0] idx_t;

    idx_t                prio_q, prio_d;
    logic                lock_q, lock_d;
    idx_t                lockIdx_q, lockIdx_d;
    logic [NumUnits-1:0] eligible;
    idx_t                winner;
    logic                anyElig;
    int unsigned         cand;
    idx_t                grantIdx;
    logic                grantValid;
    logic                handshake;
    logic                fifoFull, fifoEmpty, fifoPush, fifoPop;
    idx_t                fifoHead;
    logic [UsedW-1:0]    unusedFifoUsage;

    // Eligibility and round-robin search starting at the priority pointer.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NumUnits); i++) begin
            eligible[i] = req_valid_i[i] & (req_i[i].we | ~fifoFull);
        end
        winner  = prio_q;
        anyElig = 1'b0;
        cand    = 0;
        for (int k = int'(NumUnits) - 1; k >= 0; k--) begin
            cand = (32'(prio_q) + 32'(k)) % NumUnits;
            if (eligible[cand]) begin
                winner  = idx_t'(cand);
                anyElig = 1'b1;
            end
        end
    end

    // Grant selection with lock, way request drive and pointer/lock next state.
    always_comb begin
        grantIdx    = lock_q ? lockIdx_q : winner;
        grantValid  = (lock_q | anyElig) & rst_ni;
        way_inp_o   = req_i[grantIdx];
        way_inp_valid_o = grantValid;
        req_ready_o = '0;
        req_ready_o[grantIdx] = grantValid & way_inp_ready_i;
        handshake   = grantValid & way_inp_ready_i;
        fifoPush    = handshake & ~req_i[grantIdx].we;
        prio_d      = prio_q;
        if (handshake) begin
            prio_d = (grantIdx == idx_t'(NumUnits - 1)) ? '0 : grantIdx + idx_t'(1);
        end
        lock_d    = grantValid & ~way_inp_ready_i;
        lockIdx_d = grantIdx;
    end

    // Response steering to the unit whose read tag sits at the FIFO head.
    always_comb begin
        rsp_o           = way_oup_i;
        rsp_valid_o     = '0;
        way_oup_ready_o = 1'b1;
        fifoPop         = 1'b0;
        if (!fifoEmpty) begin
            rsp_valid_o[fifoHead] = way_oup_valid_i;
            way_oup_ready_o       = rsp_ready_i[fifoHead];
            fifoPop               = way_oup_valid_i & rsp_ready_i[fifoHead];
        end
    end

    // Priority pointer and grant lock registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q    <= '0;
            lock_q    <= 1'b0;
            lockIdx_q <= '0;
        end else begin
            prio_q    <= prio_d;
            lock_q    <= lock_d;
            lockIdx_q <= lockIdx_d;
        end
    end

    stream_fifo #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (MaxReads),
        .T            (idx_t)
    ) i_read_tag_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (test_i),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .usage_o    (unusedFifoUsage),
        .data_i     (grantIdx),
        .push_i     (fifoPush),
        .data_o     (fifoHead),
        .pop_i      (fifoPop)
    );

`ifndef SYNTHESIS
    // A read response with no outstanding read is dropped and flagged.
    always @(posedge clk_i) begin
        if (rst_ni && way_oup_valid_i) begin
            assert (!fifoEmpty)
            else $warning("way response without an outstanding read, beat dropped");
        end
    end
`endif

endmodule

// File: tb/tb_axi_llc_way_arbiter.sv
// Directed testbench for the LLC way arbiter.
module tb_axi_llc_way_arbiter;
    import axi_llc_pkg::*;

    logic              clk = 1'b0;
    logic              rstN;
    logic              testMode;
    way_inp_def_t [3:0] reqArr;
    logic [3:0]        reqValid;
    logic [3:0]        reqReady;
    way_inp_def_t      wayInp;
    logic              wayInpValid;
    logic              wayInpReady;
    way_oup_def_t      wayOup;
    logic              wayOupValid;
    logic              wayOupReady;
    way_oup_def_t      rspData;
    logic [3:0]        rspValid;
    logic [3:0]        rspReady;

    int assertCount = 0;
    int failCount   = 0;

    axi_llc_way_arbiter dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .test_i          (testMode),
        .req_i           (reqArr),
        .req_valid_i     (reqValid),
        .req_ready_o     (reqReady),
        .way_inp_o       (wayInp),
        .way_inp_valid_o (wayInpValid),
        .way_inp_ready_i (wayInpReady),
        .way_oup_i       (wayOup),
        .way_oup_valid_i (wayOupValid),
        .way_oup_ready_o (wayOupReady),
        .rsp_o           (rspData),
        .rsp_valid_o     (rspValid),
        .rsp_ready_i     (rspReady)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic way_inp_def_t mkReq(logic we, int unit);
        way_inp_def_t r;
        r.we   = we;
        r.addr = 8'(unit * 16);
        r.data = 32'hC0DE_0000 + 32'(unit);
        return r;
    endfunction

    task automatic loadPayloads(input logic [3:0] weMask);
        for (int i = 0; i < 4; i++) reqArr[i] = mkReq(weMask[i], i);
    endtask

    task automatic setIdle();
        reqValid    = 4'b0000;
        wayInpReady = 1'b1;
        wayOupValid = 1'b0;
        rspReady    = 4'b1111;
        wayOup      = 32'h0;
    endtask

    task automatic doReset();
        @(negedge clk);
        setIdle();
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        loadPayloads(4'b1111);
        rstN = 1'b0; testMode = 1'b0;
        reqValid = 4'b1111; wayInpReady = 1'b1;
        wayOupValid = 1'b1; rspReady = 4'b0000; wayOup = 32'h1234_5678;
        #2;
        assertCount++; if (reqReady !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_req_ready got=%b exp=%b", reqReady, 4'b0000); end
        assertCount++; if (wayInpValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_way_valid got=%b exp=0", wayInpValid); end
        assertCount++; if (rspValid !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_rsp_valid got=%b exp=%b", rspValid, 4'b0000); end
        assertCount++; if (wayOupReady !== 1'b1) begin failCount++; $display("[TB] FAIL reset_oup_ready got=%b exp=1", wayOupReady); end
        @(negedge clk);
        setIdle();
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_round_robin();
        int         expGrant [4];
        logic [3:0] expOneHot;
        expGrant = '{EvictUnit, WChanUnit, EvictUnit, WChanUnit};
        expGrant = '{WChanUnit, EvictUnit, WChanUnit, EvictUnit};
        doReset();
        loadPayloads(4'b1111);
        reqValid = 4'b0101; wayInpReady = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            expOneHot = 4'b0001 << expGrant[c];
            assertCount++; if (reqReady !== expOneHot) begin failCount++; $display("[TB] FAIL rr_ready_c%0d got=%b exp=%b", c, reqReady, expOneHot); end
            assertCount++; if (wayInp !== mkReq(1'b1, expGrant[c])) begin failCount++; $display("[TB] FAIL rr_payload_c%0d got=%h exp=%h", c, wayInp, mkReq(1'b1, expGrant[c])); end
            @(negedge clk);
        end
        setIdle();
    endtask

    task automatic test_lock();
        doReset();
        loadPayloads(4'b0001);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            reqValid = (c == 1) ? 4'b0010 : 4'b0011;
            wayInpReady = 1'b0;
            #1;
            assertCount++; if (wayInpValid !== 1'b1) begin failCount++; $display("[TB] FAIL lock_valid_c%0d got=%b exp=1", c, wayInpValid); end
            assertCount++; if (wayInp !== mkReq(1'b0, RChanUnit)) begin failCount++; $display("[TB] FAIL lock_payload_c%0d got=%h exp=%h", c, wayInp, mkReq(1'b0, RChanUnit)); end
            assertCount++; if (reqReady !== 4'b0000) begin failCount++; $display("[TB] FAIL lock_ready_c%0d got=%b exp=%b", c, reqReady, 4'b0000); end
        end
        @(negedge clk);
        wayInpReady = 1'b1;
        #1;
        assertCount++; if (reqReady !== 4'b0010) begin failCount++; $display("[TB] FAIL lock_grant_c4 got=%b exp=%b", reqReady, 4'b0010); end
        @(negedge clk);
        reqValid = 4'b0001;
        #1;
        assertCount++; if (reqReady !== 4'b0001) begin failCount++; $display("[TB] FAIL lock_next_c5 got=%b exp=%b", reqReady, 4'b0001); end
        assertCount++; if (wayInp !== mkReq(1'b1, WChanUnit)) begin failCount++; $display("[TB] FAIL lock_next_payload got=%h exp=%h", wayInp, mkReq(1'b1, WChanUnit)); end
        @(negedge clk);
        reqValid = 4'b0000; wayOupValid = 1'b1; wayOup = 32'hAAAA_0001; rspReady = 4'b1111;
        #1;
        assertCount++; if (rspValid !== 4'b0010) begin failCount++; $display("[TB] FAIL lock_rsp_route got=%b exp=%b", rspValid, 4'b0010); end
        assertCount++; if (rspData !== 32'hAAAA_0001) begin failCount++; $display("[TB] FAIL lock_rsp_data got=%h exp=%h", rspData, 32'hAAAA_0001); end
        @(negedge clk);
        setIdle();
    endtask

    task automatic test_fifo_full();
        doReset();
        loadPayloads(4'b0001);
        reqValid = 4'b1000;
        #1;
        assertCount++; if (reqReady !== 4'b1000) begin failCount++; $display("[TB] FAIL full_grant3 got=%b exp=%b", reqReady, 4'b1000); end
        @(negedge clk);
        reqValid = 4'b0010;
        #1;
        assertCount++; if (reqReady !== 4'b0010) begin failCount++; $display("[TB] FAIL full_grant1 got=%b exp=%b", reqReady, 4'b0010); end
        @(negedge clk);
        reqValid = 4'b0100;
        #1;
        assertCount++; if (wayInpValid !== 1'b0) begin failCount++; $display("[TB] FAIL full_stall2_valid got=%b exp=0", wayInpValid); end
        assertCount++; if (reqReady !== 4'b0000) begin failCount++; $display("[TB] FAIL full_stall2_ready got=%b exp=%b", reqReady, 4'b0000); end
        @(negedge clk);
        reqValid = 4'b0101;
        #1;
        assertCount++; if (reqReady !== 4'b0001) begin failCount++; $display("[TB] FAIL full_write0 got=%b exp=%b", reqReady, 4'b0001); end
        @(negedge clk);
        reqValid = 4'b0100;
    endtask

    task automatic test_responses();
        wayOupValid = 1'b1; wayOup = 32'hBBBB_0003; rspReady = 4'b1111;
        #1;
        assertCount++; if (wayInpValid !== 1'b0) begin failCount++; $display("[TB] FAIL resp_no_bypass got=%b exp=0", wayInpValid); end
        assertCount++; if (rspValid !== 4'b1000) begin failCount++; $display("[TB] FAIL resp_first got=%b exp=%b", rspValid, 4'b1000); end
        assertCount++; if (wayOupReady !== 1'b1) begin failCount++; $display("[TB] FAIL resp_first_ready got=%b exp=1", wayOupReady); end
        @(negedge clk);
        wayOup = 32'hBBBB_0001;
        #1;
        assertCount++; if (reqReady !== 4'b0100) begin failCount++; $display("[TB] FAIL resp_grant2 got=%b exp=%b", reqReady, 4'b0100); end
        assertCount++; if (rspValid !== 4'b0010) begin failCount++; $display("[TB] FAIL resp_second got=%b exp=%b", rspValid, 4'b0010); end
        @(negedge clk);
        reqValid = 4'b0000; wayOup = 32'hBBBB_0002;
        #1;
        assertCount++; if (rspValid !== 4'b0100) begin failCount++; $display("[TB] FAIL resp_third got=%b exp=%b", rspValid, 4'b0100); end
        @(negedge clk);
        wayOupValid = 1'b0; rspReady = 4'b0000;
        #1;
        assertCount++; if (wayOupReady !== 1'b1) begin failCount++; $display("[TB] FAIL resp_empty_ready got=%b exp=1", wayOupReady); end
        @(negedge clk);
        setIdle();
    endtask

    task automatic test_back_to_back();
        doReset();
        loadPayloads(4'b0000);
        reqValid = 4'b0010;
        #1;
        assertCount++; if (reqReady !== 4'b0010) begin failCount++; $display("[TB] FAIL b2b_grant1 got=%b exp=%b", reqReady, 4'b0010); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reqValid = 4'b0000; wayOupValid = 1'b1; rspReady = 4'b0000; wayOup = 32'hCCCC_0001;
            #1;
            assertCount++; if (rspValid !== 4'b0010) begin failCount++; $display("[TB] FAIL b2b_hold_valid_c%0d got=%b exp=%b", c, rspValid, 4'b0010); end
            assertCount++; if (wayOupReady !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_hold_ready_c%0d got=%b exp=0", c, wayOupReady); end
        end
        @(negedge clk);
        rspReady = 4'b1111; reqValid = 4'b1000;
        #1;
        assertCount++; if (rspValid !== 4'b0010) begin failCount++; $display("[TB] FAIL b2b_head_kept got=%b exp=%b", rspValid, 4'b0010); end
        assertCount++; if (reqReady !== 4'b1000) begin failCount++; $display("[TB] FAIL b2b_push_pop_grant got=%b exp=%b", reqReady, 4'b1000); end
        @(negedge clk);
        wayOupValid = 1'b0; reqValid = 4'b0001;
        #1;
        assertCount++; if (reqReady !== 4'b0001) begin failCount++; $display("[TB] FAIL b2b_occupancy_one got=%b exp=%b", reqReady, 4'b0001); end
        @(negedge clk);
        reqValid = 4'b0100;
        #1;
        assertCount++; if (wayInpValid !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_now_full got=%b exp=0", wayInpValid); end
        @(negedge clk);
        reqValid = 4'b0000; wayOupValid = 1'b1;
        #1;
        assertCount++; if (rspValid !== 4'b1000) begin failCount++; $display("[TB] FAIL b2b_drain3 got=%b exp=%b", rspValid, 4'b1000); end
        @(negedge clk);
        #1;
        assertCount++; if (rspValid !== 4'b0001) begin failCount++; $display("[TB] FAIL b2b_drain0 got=%b exp=%b", rspValid, 4'b0001); end
        @(negedge clk);
        setIdle();
    endtask

    task automatic test_reset_midflight();
        doReset();
        loadPayloads(4'b0001);
        reqValid = 4'b0010;
        #1;
        assertCount++; if (reqReady !== 4'b0010) begin failCount++; $display("[TB] FAIL mid_grant1 got=%b exp=%b", reqReady, 4'b0010); end
        @(negedge clk);
        reqValid = 4'b0100;
        #1;
        assertCount++; if (reqReady !== 4'b0100) begin failCount++; $display("[TB] FAIL mid_grant2 got=%b exp=%b", reqReady, 4'b0100); end
        @(negedge clk);
        rstN = 1'b0;
        reqValid = 4'b0001; wayOupValid = 1'b1; rspReady = 4'b1111; wayOup = 32'hDDDD_0000;
        #1;
        assertCount++; if (reqReady !== 4'b0000) begin failCount++; $display("[TB] FAIL mid_rst_req_ready got=%b exp=%b", reqReady, 4'b0000); end
        assertCount++; if (wayInpValid !== 1'b0) begin failCount++; $display("[TB] FAIL mid_rst_way_valid got=%b exp=0", wayInpValid); end
        assertCount++; if (rspValid !== 4'b0000) begin failCount++; $display("[TB] FAIL mid_rst_rsp_valid got=%b exp=%b", rspValid, 4'b0000); end
        assertCount++; if (wayOupReady !== 1'b1) begin failCount++; $display("[TB] FAIL mid_rst_oup_ready got=%b exp=1", wayOupReady); end
        @(negedge clk);
        rstN = 1'b1;
        loadPayloads(4'b1111);
        reqValid = 4'b1111; rspReady = 4'b0000;
        #1;
        assertCount++; if (reqReady !== 4'b0001) begin failCount++; $display("[TB] FAIL mid_ptr_zero got=%b exp=%b", reqReady, 4'b0001); end
        assertCount++; if (rspValid !== 4'b0000) begin failCount++; $display("[TB] FAIL mid_spurious_rsp got=%b exp=%b", rspValid, 4'b0000); end
        assertCount++; if (wayOupReady !== 1'b1) begin failCount++; $display("[TB] FAIL mid_spurious_ready got=%b exp=1", wayOupReady); end
        @(negedge clk);
        setIdle();
    endtask

    // Watchdog so the run always ends even if the schedule stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_fifo_full();
        test_responses();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
